// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input registered selector behind a 2-entry skid buffer with valid/ready, flush and sticky bad-select flag
module mux_n_pipe #(
  parameter int BUS_WIDTH = 32,
  parameter int N_INPUTS  = 4,
  parameter int SEL_W     = $clog2(N_INPUTS)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [SEL_W-1:0]              i_sel,
  input  logic [N_INPUTS*BUS_WIDTH-1:0] i_dato,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [BUS_WIDTH-1:0]          o_dato,
  output logic                          o_valid,
  input  logic                          i_ready,
  input  logic                          i_flush,
  output logic                          o_sel_err
);
  localparam int N_CH = 1 << SEL_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [BUS_WIDTH-1:0] ch [N_CH];
  logic [N_CH-1:0] in_range;
  logic [BUS_WIDTH-1:0] main_q, skid_q, sel_word;
  logic accept, consume;
  // select codes past the last channel fall back to channel 0
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    if (k < N_INPUTS) begin : g_in
      assign ch[k] = i_dato[k*BUS_WIDTH +: BUS_WIDTH];
      assign in_range[k] = 1'b1;
    end else begin : g_oor
      assign ch[k] = i_dato[BUS_WIDTH-1:0];
      assign in_range[k] = 1'b0;
    end
  end
  assign sel_word = ch[i_sel];
  assign o_valid  = state != EMPTY;
  assign o_ready  = state != FULL;
  assign o_dato   = main_q;
  assign accept   = i_valid && o_ready;
  assign consume  = o_valid && i_ready;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      o_sel_err <= 1'b0;
    end else begin
      if (accept && !in_range[i_sel]) o_sel_err <= 1'b1;
      if (i_flush) begin
        state  <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        case (state)
          EMPTY: if (accept) begin
            state  <= ONE;
            main_q <= sel_word;
          end
          ONE: if (accept && consume) main_q <= sel_word;
            else if (accept) begin
              state  <= FULL;
              skid_q <= sel_word;
            end else if (consume) state <= EMPTY;
          FULL: if (consume) begin
            state  <= ONE;
            main_q <= skid_q;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-input, BUS_WIDTH-bit selector with a registered output stage and a valid/ready handshake.
- The output stage is a 2-entry skid buffer, so it sustains full throughput with backpressure.
- A flush input clears it. A sticky flag records out-of-range selects.
- Used between MIPS pipeline stages wherever an operand or forwarding selection must be registered and stallable.

Parameters:
- BUS_WIDTH, 32: width of each data channel and of o_dato.
- N_INPUTS, 4: number of selectable channels; legal range 2..16.
- SEL_W, $clog2(N_INPUTS): width of i_sel; minimum 1.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_sel  input  SEL_W  channel select, sampled with the input beat.
- i_dato  input  N_INPUTS*BUS_WIDTH  packed channels; channel k occupies bits [k*BUS_WIDTH +: BUS_WIDTH].
- i_valid  input  1  upstream beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- o_dato  output  BUS_WIDTH  selected, registered data.
- o_valid  output  1  o_dato holds a valid beat.
- i_ready  input  1  downstream accepts o_dato this cycle.
- i_flush  input  1  synchronous discard of all held beats.
- o_sel_err  output  1  sticky flag: some accepted beat had i_sel >= N_INPUTS.

Behaviour:
- Selection: the selected word is the channel i_sel. If i_sel >= N_INPUTS, channel 0 is used; this matches the default-to-input-0 rule of the existing 2:1 mux.
- Acceptance: a beat is accepted when i_valid && o_ready. It is consumed downstream when o_valid && i_ready.
- Storage: main register (MAIN, drives o_dato/o_valid) and skid register (SKID). Both hold the already-selected word.
- o_ready = !skid_valid. It is a registered-state output with no combinational path from i_ready.
- Latency: 1 cycle from acceptance to o_valid when not stalled. Back-to-back throughput is 1 beat/cycle while i_ready=1.
- States:
  - EMPTY: MAIN invalid, SKID invalid.
  - ONE: MAIN valid, SKID invalid.
  - FULL: MAIN valid, SKID valid.
- EMPTY:
  - accept -> ONE; MAIN <= selected word.
- ONE:
  - accept && consume -> ONE; MAIN <= new word.
  - accept && !consume -> FULL; SKID <= new word.
  - !accept && consume -> EMPTY.
  - otherwise hold.
- FULL (o_ready=0, no accept possible):
  - consume -> ONE; MAIN <= SKID.
  - otherwise hold.
- Ordering: strictly FIFO. No beat is duplicated or dropped except by flush or reset.
- Flush:
  - i_flush=1 forces EMPTY next cycle, and MAIN and SKID data are cleared to 0.
  - A same-cycle accept is discarded.
  - The handshake is still evaluated for that cycle: o_ready reflects current state, and a downstream consume in that cycle is valid.
  - o_sel_err is not affected by flush.
- o_sel_err: set the cycle after any accepted beat with i_sel >= N_INPUTS, including a beat discarded by a same-cycle flush. Cleared only by reset.
- Reset:
  - i_reset=1 for one or more edges: o_valid=0, o_dato=0, skid_valid=0, o_sel_err=0, state EMPTY.
  - Inputs during reset are ignored.
  - o_ready=1 on the first cycle after reset deasserts.
  - Reset mid-stream drops all held beats.
  - Reset has priority over flush.
- Stability: o_dato and o_valid must not change while o_valid=1 && i_ready=0 (except on flush or reset).

Test Plan:
- Reset, then stream with N_INPUTS=4, BUS_WIDTH=32:
  - Stimulus: channels = 0x11111111..0x44444444, i_sel = 0,1,2,3 on consecutive cycles, i_valid=1, i_ready=1.
  - Response: o_dato = 0x11111111, 0x22222222, 0x33333333, 0x44444444 one cycle later, o_valid continuous, o_ready stays 1.
- Backpressure:
  - Stimulus: i_ready=0 while sending beats A, B, C.
  - Response: A accepted (o_valid), B accepted into SKID, then o_ready=0 and C held upstream. Raising i_ready yields A, B, C in order, no loss or duplication, and o_dato stable while stalled.
- Out-of-range select:
  - Stimulus: N_INPUTS=3, SEL_W=2, i_sel=3, channel0=0xDEAD0000.
  - Response: o_dato=0xDEAD0000 and o_sel_err=1 next cycle. It stays 1 through a flush and clears only on i_reset.
- Flush in FULL:
  - Stimulus: i_flush=1 with i_valid=1 in the same cycle.
  - Response: next cycle o_valid=0, o_dato=0, o_ready=1, and the flushed-cycle input does not appear.
- Reset mid-operation:
  - Stimulus: assert i_reset in FULL, together with i_flush and i_valid.
  - Response: all outputs 0 next cycle, o_ready=1 the cycle after reset drops, and the first post-reset beat appears with 1-cycle latency.
- Random soak:
  - Stimulus: random i_valid, i_ready, i_sel, i_flush over 10k cycles against a FIFO scoreboard.
  - Response: scoreboard matches, and o_ready never 1 while SKID is valid.
